mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mult_div_unit_div_step.sv | 34 +++
 rtl/mult_div_unit.sv | 174 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: word width, default
// iteration count, FSM state encoding and a small magnitude helper.
// The DIVZ state only exists when DIV0_EXC_EN is defined.
package mips_pkg;

  localparam int WORD_W         = 32;
  localparam int N_ITER_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
`ifdef DIV0_EXC_EN
    DONE = 3'd3,
    DIVZ = 3'd4
`else
    DONE = 3'd3
`endif
  } state_t;

  // Absolute value of a two's complement word; 0x80000000 maps to 2^31,
  // which is still representable when the result is read as unsigned.
  function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] value);
    return value[WORD_W-1] ? -value : value;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on unsigned magnitudes. The next dividend bit
// is shifted into the partial remainder; the divisor is subtracted if it
// fits, and the resulting quotient bit is shifted into the quotient word.
module div_step
  import mips_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0] w_shifted;
  logic [W:0] w_diff;

  // The partial remainder is always below the divisor (at most 2^(W-1)),
  // so the shifted value fits in W+1 bits and the top bit of the
  // difference is a reliable borrow flag.
  always_comb begin
    w_shifted = {i_rem, i_quo[W-1]};
    w_diff    = w_shifted - {1'b0, i_divisor};
    if (!w_diff[W]) begin
      o_rem = w_diff[W-1:0];
      o_quo = {i_quo[W-2:0], 1'b1};
    end else begin
      o_rem = w_shifted[W-1:0];
      o_quo = {i_quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit. Multiply uses radix-2 Booth, one
// step per cycle; divide uses restoring division on magnitudes with a sign
// fix-up on the final step. HI/LO are written only on the transition into
// DONE, so they never show partial results.
// Optional macro DIV0_EXC_EN: a divide with B==0 goes to DIVZ and pulses
// Div0 instead of running the full division.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MultOp,
  input  logic              DivOp,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic [WORD_W-1:0] HI,
  output logic [WORD_W-1:0] LO,
  output logic              Busy,
  output logic              Done,
  output logic              Div0
);

  localparam int CNT_W = $clog2(N_ITER + 1);
  localparam int PW    = 2 * WORD_W + 2;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_count;
  logic              w_lastStep;

  // Booth register layout: {accumulator (WORD_W+1), multiplier (WORD_W), q-1}.
  // The extra accumulator bit keeps -2^31 * -2^31 from overflowing.
  logic [PW-1:0]     r_booth;
  logic [PW-1:0]     w_boothNext;
  logic [WORD_W:0]   w_mcandExt;
  logic [WORD_W:0]   w_accSum;
  logic [WORD_W-1:0] r_mcand;

  logic [WORD_W-1:0] r_rem;
  logic [WORD_W-1:0] r_quo;
  logic [WORD_W-1:0] r_divisor;
  logic [WORD_W-1:0] w_remNext;
  logic [WORD_W-1:0] w_quoNext;
  logic              r_negQuo;
  logic              r_negRem;

  logic [WORD_W-1:0] r_hi;
  logic [WORD_W-1:0] r_lo;

  assign w_lastStep = (r_count == CNT_W'(N_ITER - 1));

  div_step #(
    .W(WORD_W)
  ) u_divStep (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_divisor),
    .o_rem    (w_remNext),
    .o_quo    (w_quoNext)
  );

  // One Booth step: add or subtract the multiplicand according to the
  // low bit pair, then arithmetic-shift the whole register right by one.
  always_comb begin
    w_mcandExt = {r_mcand[WORD_W-1], r_mcand};
    case (r_booth[1:0])
      2'b01:   w_accSum = r_booth[PW-1 -: WORD_W+1] + w_mcandExt;
      2'b10:   w_accSum = r_booth[PW-1 -: WORD_W+1] - w_mcandExt;
      default: w_accSum = r_booth[PW-1 -: WORD_W+1];
    endcase
    w_boothNext = {w_accSum[WORD_W], w_accSum, r_booth[WORD_W:1]};
  end

  // State register; reset wins over any start request or ongoing operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; start requests are only looked at in IDLE and
  // multiply takes priority when both are raised together.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (MultOp) begin
          w_nextState = MULT;
        end else if (DivOp) begin
`ifdef DIV0_EXC_EN
          w_nextState = (B == '0) ? DIVZ : DIV;
`else
          w_nextState = DIV;
`endif
        end
      end
      MULT:    w_nextState = w_lastStep ? DONE : MULT;
      DIV:     w_nextState = w_lastStep ? DONE : DIV;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: latch operands on the start edge, iterate one step per cycle,
  // and commit HI/LO (with divide sign fix-up) on the final step only.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count   <= '0;
      r_booth   <= '0;
      r_mcand   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_negQuo  <= 1'b0;
      r_negRem  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (MultOp) begin
            r_mcand <= A;
            r_booth <= {{(WORD_W + 1){1'b0}}, B, 1'b0};
          end else if (DivOp) begin
            r_rem     <= '0;
            r_quo     <= magnitude(A);
            r_divisor <= magnitude(B);
            r_negQuo  <= A[WORD_W-1] ^ B[WORD_W-1];
            r_negRem  <= A[WORD_W-1];
          end
        end
        MULT: begin
          r_booth <= w_boothNext;
          r_count <= r_count + CNT_W'(1);
          if (w_lastStep) begin
            r_hi <= w_boothNext[2*WORD_W -: WORD_W];
            r_lo <= w_boothNext[WORD_W:1];
          end
        end
        DIV: begin
          r_rem   <= w_remNext;
          r_quo   <= w_quoNext;
          r_count <= r_count + CNT_W'(1);
          if (w_lastStep) begin
            r_lo <= r_negQuo ? -w_quoNext : w_quoNext;
            r_hi <= r_negRem ? -w_remNext : w_remNext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs decoded directly from the current state.
  always_comb begin
    Busy = (r_state != IDLE);
    Done = (r_state == DONE);
`ifdef DIV0_EXC_EN
    Div0 = (r_state == DIVZ);
`else
    Div0 = 1'b0;
`endif
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit. Each operation is started
// on edge 0 and watched over the following cycles; expected results are
// hand-computed constants.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        MultOp;
  logic        DivOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;
  logic        Div0;

  int checks = 0;
  int passes = 0;

  int doneCycle;
  int doneCount;
  int busyFirst;
  int busyLast;
  int busyCount;
  int div0Cycle;
  int div0Count;
  int partialSeen;
  int earlyDone;

  logic [63:0] held;

  mult_div_unit #(
    .N_ITER(32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .MultOp(MultOp),
    .DivOp (DivOp),
    .A     (A),
    .B     (B),
    .HI    (HI),
    .LO    (LO),
    .Busy  (Busy),
    .Done  (Done),
    .Div0  (Div0)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the DUT or bench wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a start request for one edge, then scramble A/B so the result
  // depends only on the values latched at the start edge.
  task automatic applyStimulus(input logic mult, input logic div,
                               input logic [31:0] a, input logic [31:0] b);
    MultOp = mult;
    DivOp  = div;
    A      = a;
    B      = b;
    tick();
    MultOp = 1'b0;
    DivOp  = 1'b0;
    A      = 32'hDEADBEEF;
    B      = 32'h0BADF00D;
  endtask

  // Observe cycles 1..36 after a start edge; optionally re-pulse both
  // start requests in one cycle to show they are ignored while busy.
  task automatic watchOp(input int repulseAt, input logic [63:0] heldHiLo);
    doneCycle   = 0;
    doneCount   = 0;
    busyFirst   = 0;
    busyLast    = 0;
    busyCount   = 0;
    div0Cycle   = 0;
    div0Count   = 0;
    partialSeen = 0;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      if (Busy === 1'b1) begin
        busyCount++;
        if (busyFirst == 0) busyFirst = cyc;
        busyLast = cyc;
      end
      if (Done === 1'b1) begin
        doneCount++;
        if (doneCycle == 0) doneCycle = cyc;
      end
      if (Div0 === 1'b1) begin
        div0Count++;
        if (div0Cycle == 0) div0Cycle = cyc;
      end
      if (doneCycle == 0 && {HI, LO} !== heldHiLo) partialSeen++;
      if (cyc == repulseAt) begin
        MultOp = 1'b1;
        DivOp  = 1'b1;
        A      = 32'h00000003;
        B      = 32'h00000005;
      end
      tick();
      MultOp = 1'b0;
      DivOp  = 1'b0;
    end
  endtask

  task automatic checkRun(input string tag, input logic [31:0] expHi,
                          input logic [31:0] expLo);
    checkOutput({tag, ".doneCycle"}, 64'(doneCycle), 64'd33);
    checkOutput({tag, ".doneCount"}, 64'(doneCount), 64'd1);
    checkOutput({tag, ".busyFirst"}, 64'(busyFirst), 64'd1);
    checkOutput({tag, ".busyLast"}, 64'(busyLast), 64'd33);
    checkOutput({tag, ".busyCount"}, 64'(busyCount), 64'd33);
    checkOutput({tag, ".div0Count"}, 64'(div0Count), 64'd0);
    checkOutput({tag, ".partial"}, 64'(partialSeen), 64'd0);
    checkOutput({tag, ".HI"}, 64'(HI), 64'(expHi));
    checkOutput({tag, ".LO"}, 64'(LO), 64'(expLo));
  endtask

  initial begin
    reset  = 1'b1;
    MultOp = 1'b0;
    DivOp  = 1'b0;
    A      = '0;
    B      = '0;
    tick();
    MultOp = 1'b1;
    tick();
    MultOp = 1'b0;

    // Reset state, even with a start request present
    checkOutput("reset.HI", 64'(HI), 64'd0);
    checkOutput("reset.LO", 64'(LO), 64'd0);
    checkOutput("reset.Busy", 64'(Busy), 64'd0);
    checkOutput("reset.Done", 64'(Done), 64'd0);
    checkOutput("reset.Div0", 64'(Div0), 64'd0);

    // First edge out of reset accepts a start: 7 * -3 = -21
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD);
    watchOp(0, 64'h0);
    checkRun("mul7xm3", 32'hFFFFFFFF, 32'hFFFFFFEB);
    held = 64'hFFFFFFFF_FFFFFFEB;

    // -7 / 2 = -3 rem -1
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002);
    watchOp(0, held);
    checkRun("divm7by2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    held = 64'hFFFFFFFF_FFFFFFFD;

    // 7 / -2 = -3 rem 1
    applyStimulus(1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE);
    watchOp(0, held);
    checkRun("div7bym2", 32'h00000001, 32'hFFFFFFFD);
    held = 64'h00000001_FFFFFFFD;

    // Most negative / -1 wraps to itself, remainder 0
    applyStimulus(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    watchOp(0, held);
    checkRun("divMinByM1", 32'h00000000, 32'h80000000);
    held = 64'h00000000_80000000;

    // Most negative squared = 2^62
    applyStimulus(1'b1, 1'b0, 32'h80000000, 32'h80000000);
    watchOp(0, held);
    checkRun("mulMinSq", 32'h40000000, 32'h00000000);
    held = 64'h40000000_00000000;

    // Both starts together: multiply wins, 6 * 7 = 42
    applyStimulus(1'b1, 1'b1, 32'h00000006, 32'h00000007);
    watchOp(0, held);
    checkRun("mulPriority", 32'h00000000, 32'h0000002A);
    held = 64'h00000000_0000002A;

    // Re-pulsed starts at cycle 5 are ignored: 0x10000 * 0x10000 = 2^32
    applyStimulus(1'b1, 1'b0, 32'h00010000, 32'h00010000);
    watchOp(5, held);
    checkRun("mulRepulse", 32'h00000001, 32'h00000000);
    held = 64'h00000001_00000000;

    // Divide by zero, negative dividend
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000000);
    watchOp(0, held);
`ifdef DIV0_EXC_EN
    checkOutput("divz1.div0Cycle", 64'(div0Cycle), 64'd1);
    checkOutput("divz1.div0Count", 64'(div0Count), 64'd1);
    checkOutput("divz1.doneCount", 64'(doneCount), 64'd0);
    checkOutput("divz1.busyCount", 64'(busyCount), 64'd1);
    checkOutput("divz1.partial", 64'(partialSeen), 64'd0);
`else
    checkRun("divz1", 32'hFFFFFFF9, 32'h00000001);
    held = 64'hFFFFFFF9_00000001;
`endif

    // Divide by zero, positive dividend
    applyStimulus(1'b0, 1'b1, 32'h00000064, 32'h00000000);
    watchOp(0, held);
`ifdef DIV0_EXC_EN
    checkOutput("divz2.div0Cycle", 64'(div0Cycle), 64'd1);
    checkOutput("divz2.doneCount", 64'(doneCount), 64'd0);
    checkOutput("divz2.HI", 64'(HI), 64'(held[63:32]));
    checkOutput("divz2.LO", 64'(LO), 64'(held[31:0]));
`else
    checkRun("divz2", 32'h00000064, 32'hFFFFFFFF);
`endif

    // Reset at cycle 10 of a multiply aborts it
    applyStimulus(1'b1, 1'b0, 32'h00000005, 32'h00000006);
    earlyDone = 0;
    for (int c = 1; c < 10; c++) begin
      if (Done === 1'b1) earlyDone++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midReset.HI", 64'(HI), 64'd0);
    checkOutput("midReset.LO", 64'(LO), 64'd0);
    checkOutput("midReset.Busy", 64'(Busy), 64'd0);
    checkOutput("midReset.Done", 64'(Done), 64'd0);
    checkOutput("midReset.earlyDone", 64'(earlyDone), 64'd0);

    // Start issued in cycle 11 is accepted: 3 * 4 = 12
    applyStimulus(1'b1, 1'b0, 32'h00000003, 32'h00000004);
    watchOp(0, 64'h0);
    checkRun("mulAfterReset", 32'h00000000, 32'h0000000C);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
